stupidrv_memarb: RTL and testbench
==================================

// Module: stupidrv_memarb
// PURPOSE
//  Arbitrates a single-port synchronous SRAM between the core's instruction-fetch
//  requester (I) and its data load/store requester (D). Grants one access per cycle
//  and routes read data back to the owner one cycle later. Drives the core's stall
//  input whenever a request loses arbitration. Data side has priority; a streak
//  limit guarantees fetch forward progress.
// PARAMETERS
//  MEM_WORDS   1024  SRAM depth in 32-bit words; AW = $clog2(MEM_WORDS)
//  MAX_STREAK  3     max consecutive D grants while I waits before I is forced
// PORTS
//  clock      in   1   single clock, all state on posedge
//  reset      in   1   asynchronous, active-high; clears all state
//  i_req      in   1   fetch request
//  i_addr     in   32  fetch byte address (bits [1:0] ignored)
//  i_gnt      out  1   fetch accepted this cycle
//  i_rvalid   out  1   i_rdata valid (cycle after i_gnt)
//  i_rdata    out  32  fetch data
//  d_req      in   1   data request
//  d_addr     in   32  data byte address (bits [1:0] ignored)
//  d_wstrb    in   4   byte write enables; 0 = read
//  d_wdata    in   32  write data
//  d_gnt      out  1   data accepted this cycle
//  d_rvalid   out  1   d_rdata valid (cycle after a read d_gnt)
//  d_rdata    out  32  load data
//  stall      out  1   (i_req && !i_gnt) || (d_req && !d_gnt)
//  mem_en     out  1   SRAM access enable
//  mem_addr   out  AW  SRAM word address = granted addr[AW+1:2]; upper bits wrap
//  mem_wstrb  out  4   SRAM byte write enables (0 for fetch)
//  mem_wdata  out  32  SRAM write data
//  mem_rdata  in   32  SRAM read data, valid 1 cycle after mem_en with wstrb==0
// BEHAVIOUR
//  - Grant logic combinational from req + state; one grant per cycle max.
//  - D only: d_gnt=1. I only: i_gnt=1. Neither: mem_en=0, mem_wstrb=0.
//  - Both: d_gnt=1 unless streak==MAX_STREAK, then i_gnt=1.
//  - streak (saturating, $clog2(MAX_STREAK+1) bits): +1 on D grant while i_req
//    high and I not granted; cleared on any I grant or any cycle with i_req=0.
//  - mem_* mirror the granted requester; fetch forces mem_wstrb=0.
//  - Response: owner register (NONE/I/D) loaded at grant; reads only. Next cycle
//    the owner's rvalid=1 and rdata=mem_rdata; other rvalid=0. D write => owner
//    NONE, no d_rvalid. rdata of non-owner is don't-care (drive mem_rdata).
//  - Requesters must hold req/addr/wstrb/wdata stable until gnt.
//  - Latency: read response exactly 1 cycle after grant; no queuing, no
//    outstanding beyond one; back-to-back grants every cycle allowed.
//  - Reset (async): streak=0, owner=NONE; i_rvalid=d_rvalid=0. While reset is
//    high gnt outputs, mem_en, mem_wstrb and stall are 0. A response in flight at
//    reset assertion is dropped, never delivered after release.
//  - Write then read to same word on consecutive grants: read returns new data
//    (SRAM is read-after-write coherent across cycles).
// TESTING
//  1. I only, addr 0x10 for 4 cycles, SRAM word4=0xDEADBEEF -> i_gnt every cycle,
//     i_rvalid each following cycle, i_rdata=0xDEADBEEF, stall=0.
//  2. I and D read simultaneously, d_addr 0x20 -> d_gnt, stall=1, next cycle
//     d_rvalid=1 with word8, i_rvalid=0; I granted in the cycle after D drops.
//  3. I held + D held 6 cycles, MAX_STREAK=3 -> grants D,D,D,I,D,D,D; stall=1
//     throughout; streak reset after I grant.
//  4. D write wstrb=4'b0011 data 0x12345678 to 0x40, then D read 0x40 -> no
//     d_rvalid after write; read returns upper bytes old, low half 0x5678.
//  5. Assert reset one cycle after D read grant -> d_rvalid stays 0; post-release
//     no spurious rvalid, streak=0, first I request granted immediately.
//  6. d_addr = MEM_WORDS*4 + 8 -> mem_addr = 2 (wrap), data from word 2.

Source files
------------

// File: rtl/stupidrv_memarb.sv
// Shares one single-port synchronous SRAM between instruction fetch (I) and data
// load/store (D). Data wins ties, but a streak limit forces fetch through.
module stupidrv_memarb #(
  parameter int MEM_WORDS  = 1024,
  parameter int MAX_STREAK = 3,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic [31:0]   d_addr,
  input  logic [3:0]    d_wstrb,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          stall,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_wstrb,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  logic [SW-1:0] streak;
  owner_t        owner_p1;
  owner_t        owner_nxt;
  logic          force_i;

  // Stage 0: combinational arbitration and SRAM request mux
  always_comb begin
    force_i   = (streak == STREAK_MAX);
    d_gnt     = !reset && d_req && !(i_req && force_i);
    i_gnt     = !reset && i_req && !d_gnt;
    stall     = !reset && ((i_req && !i_gnt) || (d_req && !d_gnt));
    mem_en    = i_gnt || d_gnt;
    mem_addr  = d_gnt ? d_addr[AW+1:2] : i_addr[AW+1:2];
    mem_wstrb = d_gnt ? d_wstrb : 4'b0000;
    mem_wdata = d_wdata;
  end

  // Only reads produce a response; a D write leaves nothing in flight.
  always_comb begin
    owner_nxt = OWN_NONE;
    if (i_gnt) begin
      owner_nxt = OWN_I;
    end else if (d_gnt && (d_wstrb == 4'b0000)) begin
      owner_nxt = OWN_D;
    end
  end

  // Stage 1: response owner and fetch-starvation streak
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_p1 <= OWN_NONE;
      streak   <= '0;
    end else begin
      owner_p1 <= owner_nxt;
      if (!i_req || i_gnt) begin
        streak <= '0;
      end else if (d_gnt && (streak != STREAK_MAX)) begin
        streak <= streak + SW'(1);
      end
    end
  end

  assign i_rvalid = (owner_p1 == OWN_I);
  assign d_rvalid = (owner_p1 == OWN_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_stupidrv_memarb.sv
// Directed and randomized checks of stupidrv_memarb against a cycle-level
// reference model (arbitration rules, shadow memory, one-deep response slot).
module tb_stupidrv_memarb;

  localparam int MEM_WORDS  = 1024;
  localparam int MAX_STREAK = 3;
  localparam int AW = $clog2(MEM_WORDS);

  logic          clock;
  logic          reset;
  logic          i_req;
  logic [31:0]   i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic [31:0]   d_addr;
  logic [3:0]    d_wstrb;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          stall;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] init_mem [MEM_WORDS];
  logic [31:0] sram     [MEM_WORDS];
  logic [31:0] ref_mem  [MEM_WORDS];
  logic        load;

  int          m_streak;
  int          pend_owner;   // 0 none, 1 fetch, 2 data
  logic [31:0] pend_data;
  bit          last_ig;
  bit          last_dg;

  stupidrv_memarb #(.MEM_WORDS(MEM_WORDS), .MAX_STREAK(MAX_STREAK)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .stall(stall), .mem_en(mem_en), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural single-port synchronous SRAM
  always @(posedge clock) begin
    if (load) begin
      for (int i = 0; i < MEM_WORDS; i++) sram[i] <= init_mem[i];
    end else if (mem_en) begin
      if (mem_wstrb != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    bit eig, edg, estall;
    int idx;
    logic [31:0] a;
    if (reset) begin
      eig = 0; edg = 0;
    end else if (i_req && d_req) begin
      edg = (m_streak != MAX_STREAK);
      eig = !edg;
    end else begin
      eig = i_req; edg = d_req;
    end
    estall = !reset && ((i_req && !eig) || (d_req && !edg));
    chk("i_gnt", {31'b0, i_gnt}, {31'b0, eig});
    chk("d_gnt", {31'b0, d_gnt}, {31'b0, edg});
    chk("stall", {31'b0, stall}, {31'b0, estall});
    chk("mem_en", {31'b0, mem_en}, {31'b0, eig | edg});
    chk("i_rvalid", {31'b0, i_rvalid}, {31'b0, (!reset && pend_owner == 1)});
    chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, (!reset && pend_owner == 2)});
    if (!reset && pend_owner == 1) chk("i_rdata", i_rdata, pend_data);
    if (!reset && pend_owner == 2) chk("d_rdata", d_rdata, pend_data);
    a = edg ? d_addr : i_addr;
    idx = int'((a >> 2) % MEM_WORDS);
    if (eig || edg) begin
      chk("mem_addr", 32'(mem_addr), 32'(idx));
      chk("mem_wstrb", 32'(mem_wstrb), edg ? 32'(d_wstrb) : 32'd0);
      if (edg && d_wstrb != 4'b0000) chk("mem_wdata", mem_wdata, d_wdata);
    end else begin
      chk("mem_wstrb_idle", 32'(mem_wstrb), 32'd0);
    end
    // advance the model across the coming clock edge
    if (reset) begin
      m_streak = 0;
      pend_owner = 0;
    end else begin
      pend_owner = 0;
      if (eig) begin
        pend_owner = 1; pend_data = ref_mem[idx];
      end else if (edg && d_wstrb == 4'b0000) begin
        pend_owner = 2; pend_data = ref_mem[idx];
      end else if (edg) begin
        for (int b = 0; b < 4; b++)
          if (d_wstrb[b]) ref_mem[idx][8*b +: 8] = d_wdata[8*b +: 8];
      end
      if (!i_req || eig) m_streak = 0;
      else if (edg && m_streak < MAX_STREAK) m_streak++;
    end
    last_ig = eig;
    last_dg = edg;
  endtask

  task automatic step(input logic rs, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic [31:0] da,
                      input logic [3:0] ws, input logic [31:0] wd);
    @(posedge clock);
    #1;
    reset = rs; i_req = ir; i_addr = ia;
    d_req = dr; d_addr = da; d_wstrb = ws; d_wdata = wd;
    @(negedge clock);
    model_check();
  endtask

  initial begin
    logic [31:0] ia, da, wd;
    logic [3:0]  ws;
    logic        ir, dr;
    logic        pat [7];
    reset = 1'b1; load = 1'b1;
    i_req = 0; i_addr = 0; d_req = 0; d_addr = 0; d_wstrb = 0; d_wdata = 0;
    m_streak = 0; pend_owner = 0; pend_data = 0; last_ig = 0; last_dg = 0;
    for (int i = 0; i < MEM_WORDS; i++) init_mem[i] = $urandom();
    init_mem[2]  = 32'h0BADF00D;
    init_mem[4]  = 32'hDEADBEEF;
    init_mem[8]  = 32'hCAFE0008;
    init_mem[16] = 32'hA5A5C3C3;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_mem[i];

    // reset holds everything quiet even with requests pending
    step(1, 1, 32'h10, 1, 32'h20, 4'h0, 0);
    step(1, 0, 0, 0, 0, 4'h0, 0);
    load = 1'b0;
    step(0, 0, 0, 0, 0, 4'h0, 0);

    // fetch only, back-to-back
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 32'h10, 0, 0, 4'h0, 0);
      if (k > 0) chk("t1_rdata", i_rdata, 32'hDEADBEEF);
    end
    step(0, 0, 0, 0, 0, 4'h0, 0);
    chk("t1_last_rdata", i_rdata, 32'hDEADBEEF);

    // simultaneous: data wins, fetch follows
    step(0, 1, 32'h10, 1, 32'h20, 4'h0, 0);
    chk("t2_stall", {31'b0, stall}, 32'd1);
    step(0, 1, 32'h10, 0, 0, 4'h0, 0);
    chk("t2_d_rdata", d_rdata, 32'hCAFE0008);
    chk("t2_i_gnt", {31'b0, i_gnt}, 32'd1);
    step(0, 0, 0, 0, 0, 4'h0, 0);

    // streak limit forces a fetch every fourth grant
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 7; k++) begin
      step(0, 1, 32'h10, 1, 32'h20, 4'h0, 0);
      chk("t3_d_pattern", {31'b0, d_gnt}, {31'b0, pat[k]});
    end
    step(0, 0, 0, 0, 0, 4'h0, 0);

    // partial write then read back
    step(0, 0, 0, 1, 32'h40, 4'b0011, 32'h12345678);
    step(0, 0, 0, 1, 32'h40, 4'b0000, 0);
    chk("t4_no_wr_rvalid", {31'b0, d_rvalid}, 32'd0);
    step(0, 0, 0, 0, 0, 4'h0, 0);
    chk("t4_merged", d_rdata, 32'hA5A55678);

    // reset drops an in-flight read
    step(0, 0, 0, 1, 32'h44, 4'h0, 0);
    step(1, 0, 0, 0, 0, 4'h0, 0);
    chk("t5_dropped", {31'b0, d_rvalid}, 32'd0);
    step(1, 0, 0, 0, 0, 4'h0, 0);
    step(0, 0, 0, 0, 0, 4'h0, 0);
    step(0, 1, 32'h10, 0, 0, 4'h0, 0);
    chk("t5_i_first", {31'b0, i_gnt}, 32'd1);
    step(0, 1, 32'h10, 1, 32'h20, 4'h0, 0);
    step(0, 0, 0, 0, 0, 4'h0, 0);

    // address wrap
    step(0, 0, 0, 1, MEM_WORDS * 4 + 8, 4'h0, 0);
    chk("t6_wrap_addr", 32'(mem_addr), 32'd2);
    step(0, 0, 0, 0, 0, 4'h0, 0);
    chk("t6_wrap_data", d_rdata, 32'h0BADF00D);

    // randomized traffic; requests stay stable until granted
    for (int n = 0; n < 600; n++) begin
      ir = i_req; ia = i_addr;
      dr = d_req; da = d_addr; ws = d_wstrb; wd = d_wdata;
      if (!(i_req && !last_ig)) begin
        ir = 1'($urandom_range(0, 1));
        ia = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 63));
      end
      if (!(d_req && !last_dg)) begin
        dr = 1'($urandom_range(0, 1));
        da = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 63));
        ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        wd = $urandom();
      end
      step(0, ir, ia, dr, da, ws, wd);
    end
    step(0, 0, 0, 0, 0, 4'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
